hash_wb_ctrl: RTL and testbench
===============================

# hash_wb_ctrl

Parametrised Wishbone slave that fronts a multi-word hash engine such as SHA-1 and generalises the single-purpose SHA-1 register block. It collects MSG_WORDS message words, hands the block to an external compression core with a start/done handshake, latches DIGEST_WORDS digest words, and serves them back over the bus. It adds a maskable interrupt, a write-1-to-clear done flag, an overrun error flag and an optional watchdog.

## Interface
- BASE_ADDRESS, 32'h30000024: byte address of register 0.
- MSG_WORDS, 16: message words per block (2..64).
- DIGEST_WORDS, 5: digest words (1..16).
- CORE_ID, 32'h53484131: value returned by the ID register.
- TIMEOUT, 1024: watchdog limit in cycles; used only with HASH_WB_WATCHDOG_EN.
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_ni  in  1  reset, asynchronous and active-low.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe, cycle and write-enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i, wbs_dat_i  in  32 each  address and write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- msg_o  out  32*MSG_WORDS  message block; word k is at bits [32k+31:32k].
- start_o  out  1  one-cycle start pulse to the core.
- core_rst_o  out  1  one-cycle soft reset pulse to the core.
- core_done_i  in  1  core completion strobe.
- digest_i  in  32*DIGEST_WORDS  core digest; word k is at bits [32k+31:32k].
- done  out  1  high while in state DONE.
- irq  out  1  interrupt, level-sensitive.

## Operation
- Register offsets from BASE_ADDRESS:
  - 0x00 NR: reads 5.
  - 0x04 ID: reads CORE_ID.
  - 0x08 CTRL/STATUS.
  - 0x0C MSG_IN.
  - 0x10 DIGEST.
- Any unmapped read returns EINVAL 32'h0fffffea. Unmapped writes have no effect. Every access is acked.
- Writes take effect only when wbs_sel_i == 4'hF. Other byte selects are acked with no effect.
- CTRL write bits:
  - [0] ON: clears msg_idx, dig_idx, DONE, ERR, PANIC; forces state IDLE.
  - [1] RESET: pulses core_rst_o.
  - [2] IRQ_EN: stored.
  - [3] DONE_CLR: write 1 to clear DONE and return to IDLE.
- CTRL read layout: {8'b0, dig_idx[3:0], msg_idx[5:0], 6'b0, state[1:0], ERR, PANIC, DONE, IRQ_EN, busy, 1'b0}.
- MSG_IN write, state IDLE: stores the word at msg_idx and increments msg_idx.
  - On the MSG_WORDSth word, msg_idx wraps to 0, start_o pulses on the next cycle, and the state goes to RUN.
- MSG_IN write, state RUN or DONE: word discarded, ERR set (sticky). ERR clears only on ON.
- MSG_IN read: returns EINVAL.
- DIGEST read, state DONE: returns word dig_idx, then dig_idx increments and wraps from DIGEST_WORDS-1 to 0.
- DIGEST read, any other state: returns EINVAL; dig_idx is unchanged.
- FSM states:
  - IDLE(0) -> RUN(1) on the last message word.
  - RUN -> DONE(2) on core_done_i; digest_i is latched and dig_idx set to 0 in the same cycle.
  - DONE -> IDLE on DONE_CLR or ON.
  - core_done_i outside RUN is ignored.
- busy = (state == RUN).
- irq = IRQ_EN & (DONE | PANIC).
- Simultaneous core_done_i and an ON write in the same cycle: ON wins; digest is not latched.

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, start_o=0, core_rst_o=0, done=0, irq=0, msg_o=0, state IDLE, all indices and flags 0.
- Reset asserted mid-RUN aborts immediately. start_o and core_rst_o are never left high.
- Bus handshake:
  - A request (stb & cyc) is accepted only when wbs_ack_o is low.
  - wbs_ack_o is registered: high exactly one cycle, the cycle after acceptance.
  - wbs_dat_o is valid in the ack cycle and holds until the next read.
  - Minimum 2 cycles per access; back-to-back strobes are acked every other cycle.
- Side effects (index increments, W1C clears) occur once, at acceptance.
- start_o is high the cycle after the accepted final MSG_IN write. msg_o is stable from that cycle until the next ON or the next IDLE write.
- DONE is visible in the CTRL read value the cycle after core_done_i.

## Configuration
- HASH_WB_WATCHDOG_EN defined:
  - A $clog2(TIMEOUT+1)-bit counter runs in RUN.
  - If it reaches TIMEOUT without core_done_i: PANIC set, core_rst_o pulses, state returns to IDLE.
  - The counter clears on leaving RUN.
- HASH_WB_WATCHDOG_EN undefined: no counter; PANIC reads 0; RUN waits indefinitely.

## Test plan
- Reset, then read 0x00, 0x04, 0x0C and 0x20 -> 5, 32'h53484131, 32'h0fffffea, 32'h0fffffea; each read acked 1 cycle later for exactly 1 cycle.
- Write CTRL=1, then 16 MSG_IN words 0..15 -> start_o one pulse after word 15; msg_o[31:0]=0, msg_o[511:480]=15; CTRL read shows busy=1, state=1.
- Core returns core_done_i with digest_i words A0..A4 -> done=1; six DIGEST reads return A0,A1,A2,A3,A4,A0. DIGEST read before done returns EINVAL with dig_idx still 0.
- With IRQ_EN=1, on done -> irq=1; write CTRL=8 -> irq=0, state IDLE. A MSG_IN write during RUN sets ERR; CTRL bit5=1.
- Write to MSG_IN with wbs_sel_i=4'h3 -> acked; msg_idx unchanged. Drop wb_rst_ni mid-RUN -> all outputs 0 asynchronously.
- With HASH_WB_WATCHDOG_EN and TIMEOUT=8, no core_done_i -> PANIC=1 and core_rst_o pulse 8 cycles after start_o; irq=1 if IRQ_EN; state IDLE.

Source files
------------

// File: rtl/hash_wb_ctrl_if.sv
// ============================================================================
//  Module   : hash_wb_ctrl_if
//  Brief    : Wishbone classic slave bus bundle used by hash_wb_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hash_wb_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

`default_nettype wire

// File: rtl/hash_wb_ctrl.sv
// ============================================================================
//  Module   : hash_wb_ctrl
//  Brief    : Wishbone register front-end for a multi-word hash core.
//             Collects MSG_WORDS message words, starts the core, latches
//             DIGEST_WORDS digest words and serves them back over the bus.
//             Optional watchdog: define HASH_WB_WATCHDOG_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hash_wb_ctrl #(
  parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
  parameter int          MSG_WORDS    = 16,
  parameter int          DIGEST_WORDS = 5,
  parameter logic [31:0] CORE_ID      = 32'h53484131,
  parameter int          TIMEOUT      = 1024
) (
  input  wire logic                      wb_clk_i,
  input  wire logic                      wb_rst_ni,
  hash_wb_ctrl_if.slave                  bus,
  output logic [32*MSG_WORDS-1:0]        msg_o,
  output logic                           start_o,
  output logic                           core_rst_o,
  input  wire logic                      core_done_i,
  input  wire logic [32*DIGEST_WORDS-1:0] digest_i,
  output logic                           done,
  output logic                           irq
);

  localparam logic [31:0] EINVAL     = 32'h0fffffea;
  localparam logic [31:0] OFF_NR     = 32'h00;
  localparam logic [31:0] OFF_ID     = 32'h04;
  localparam logic [31:0] OFF_CTRL   = 32'h08;
  localparam logic [31:0] OFF_MSG    = 32'h0C;
  localparam logic [31:0] OFF_DIGEST = 32'h10;
  localparam logic [31:0] NR_VALUE   = 32'd5;
  localparam logic [5:0]  MSG_LAST   = 6'(MSG_WORDS - 1);
  localparam logic [3:0]  DIG_LAST   = 4'(DIGEST_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state;
  logic [5:0]                   msg_idx;
  logic [3:0]                   dig_idx;
  logic                         err;
  logic                         panic;
  logic                         irq_en;
  logic [32*MSG_WORDS-1:0]      msg_q;
  logic [32*DIGEST_WORDS-1:0]   dig_q;
  logic [31:0]                  dig_word;
  logic [31:0]                  ctrl_rd;
  logic [31:0]                  off;
  logic                         accept;
  logic                         wr_ok;
  logic                         on_wr;
  logic                         busy;

  // Request decode: one access accepted per ack-free cycle.
  assign accept = bus.wbs_stb_i & bus.wbs_cyc_i & ~bus.wbs_ack_o;
  assign off    = bus.wbs_adr_i - BASE_ADDRESS;
  assign wr_ok  = accept & bus.wbs_we_i & (bus.wbs_sel_i == 4'hF);
  assign on_wr  = wr_ok & (off == OFF_CTRL) & bus.wbs_dat_i[0];

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign irq   = irq_en & (done | panic);
  assign msg_o = msg_q;

  assign ctrl_rd = {8'b0, dig_idx, msg_idx, 6'b0, state, err, panic, done,
                    irq_en, busy, 1'b0};

  // Select the digest word addressed by dig_idx.
  always_comb begin
    dig_word = '0;
    for (int k = 0; k < DIGEST_WORDS; k++) begin
      if (dig_idx == k[3:0]) dig_word = dig_q[32*k +: 32];
    end
  end

`ifdef HASH_WB_WATCHDOG_EN
  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_fire;

  assign wd_fire = (state == RUN) & ~core_done_i & (wd_cnt == WD_LAST);

  // Watchdog counter: runs only while the core is busy.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)        wd_cnt <= '0;
    else if (state == RUN) wd_cnt <= wd_cnt + 1'b1;
    else                   wd_cnt <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign panic          = 1'b0;
`endif

  // Control FSM, register file and bus response. Bus writes are applied
  // after core events so an ON write overrides a coincident core_done_i.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state         <= IDLE;
      msg_idx       <= '0;
      dig_idx       <= '0;
      err           <= 1'b0;
      irq_en        <= 1'b0;
      msg_q         <= '0;
      dig_q         <= '0;
      start_o       <= 1'b0;
      core_rst_o    <= 1'b0;
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
`ifdef HASH_WB_WATCHDOG_EN
      panic         <= 1'b0;
`endif
    end else begin
      bus.wbs_ack_o <= accept;
      start_o       <= 1'b0;
      core_rst_o    <= 1'b0;

      if ((state == RUN) && core_done_i && !on_wr) begin
        state   <= DONE;
        dig_q   <= digest_i;
        dig_idx <= '0;
      end

`ifdef HASH_WB_WATCHDOG_EN
      if (wd_fire) begin
        panic      <= 1'b1;
        core_rst_o <= 1'b1;
        state      <= IDLE;
      end
`endif

      if (accept && bus.wbs_we_i) begin
        if (wr_ok) begin
          case (off)
            OFF_CTRL: begin
              irq_en <= bus.wbs_dat_i[2];
              if (bus.wbs_dat_i[1]) core_rst_o <= 1'b1;
              if (bus.wbs_dat_i[3] && (state == DONE)) state <= IDLE;
              if (bus.wbs_dat_i[0]) begin
                msg_idx <= '0;
                dig_idx <= '0;
                err     <= 1'b0;
                state   <= IDLE;
`ifdef HASH_WB_WATCHDOG_EN
                panic   <= 1'b0;
`endif
              end
            end
            OFF_MSG: begin
              if (state == IDLE) begin
                for (int k = 0; k < MSG_WORDS; k++) begin
                  if (msg_idx == k[5:0]) msg_q[32*k +: 32] <= bus.wbs_dat_i;
                end
                if (msg_idx == MSG_LAST) begin
                  msg_idx <= '0;
                  start_o <= 1'b1;
                  state   <= RUN;
                end else begin
                  msg_idx <= msg_idx + 6'd1;
                end
              end else begin
                err <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end else if (accept) begin
        case (off)
          OFF_NR:   bus.wbs_dat_o <= NR_VALUE;
          OFF_ID:   bus.wbs_dat_o <= CORE_ID;
          OFF_CTRL: bus.wbs_dat_o <= ctrl_rd;
          OFF_DIGEST: begin
            if (state == DONE) begin
              bus.wbs_dat_o <= dig_word;
              dig_idx       <= (dig_idx == DIG_LAST) ? 4'd0 : dig_idx + 4'd1;
            end else begin
              bus.wbs_dat_o <= EINVAL;
            end
          end
          default:  bus.wbs_dat_o <= EINVAL;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hash_wb_ctrl.sv
// ============================================================================
//  Module   : tb_hash_wb_ctrl
//  Brief    : Randomized self-checking bench for hash_wb_ctrl with a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hash_wb_ctrl;
  localparam logic [31:0] BASE   = 32'h30000024;
  localparam logic [31:0] ID     = 32'h53484131;
  localparam logic [31:0] EINVAL = 32'h0fffffea;
  localparam int          NMSG   = 16;
  localparam int          NDIG   = 5;
  localparam int          TMO    = 32;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [32*NMSG-1:0]     msg_o;
  logic                   start_o, core_rst_o, done, irq;
  logic                   core_done_i = 1'b0;
  logic [32*NDIG-1:0]     digest_i = '0;

  hash_wb_ctrl_if bus ();

  hash_wb_ctrl #(.BASE_ADDRESS(BASE), .MSG_WORDS(NMSG), .DIGEST_WORDS(NDIG),
                 .CORE_ID(ID), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(bus), .msg_o(msg_o),
    .start_o(start_o), .core_rst_o(core_rst_o), .core_done_i(core_done_i),
    .digest_i(digest_i), .done(done), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: transaction-level view of the register block.
  int          m_state = 0;   // 0 idle, 1 running, 2 digest ready
  int          m_msg_idx = 0, m_dig_idx = 0;
  bit          m_err = 0, m_panic = 0, m_irq_en = 0;
  logic [31:0] m_msg [NMSG];
  logic [31:0] m_dig [NDIG];
  logic        start_seen, rst_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_ctrl();
    int v;
    v = (m_dig_idx << 20) | (m_msg_idx << 14) | (m_state << 6) |
        (int'(m_err) << 5) | (int'(m_panic) << 4) | (int'(m_state == 2) << 3) |
        (int'(m_irq_en) << 2) | (int'(m_state == 1) << 1);
    return 32'(v);
  endfunction

  // One Wishbone access; optionally raises core_done_i in the acceptance cycle.
  task automatic xfer(input logic we, input logic [31:0] off, input logic [31:0] data,
                      input logic [3:0] sel, input bit done_too, output logic [31:0] rdata);
    @(negedge clk);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = BASE + off; bus.wbs_dat_i = data; bus.wbs_sel_i = sel;
    if (done_too) core_done_i = 1'b1;
    @(posedge clk); #1;
    core_done_i = 1'b0;
    check("ack_high", {31'b0, bus.wbs_ack_o}, 32'd1);
    rdata      = bus.wbs_dat_o;
    start_seen = start_o;
    rst_seen   = core_rst_o;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", {31'b0, bus.wbs_ack_o}, 32'd0);
    check("pulses_low", {30'b0, start_o, core_rst_o}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    logic [31:0] d;
    xfer(1'b1, off, data, 4'hF, 1'b0, d);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] d;
    xfer(1'b0, off, 32'h0, 4'hF, 1'b0, d);
    check(tag, d, exp);
  endtask

  task automatic ctrl_write(input logic [31:0] v);
    wr(32'h08, v);
    m_irq_en = v[2];
    if (v[3] && m_state == 2) m_state = 0;
    if (v[0]) begin
      m_state = 0; m_msg_idx = 0; m_dig_idx = 0; m_err = 0; m_panic = 0;
    end
  endtask

  // Loads a full block; optionally injects a partial-select write at word bad_at.
  task automatic load_block(input int bad_at);
    logic [31:0] d;
    for (int j = 0; j < NMSG; j++) begin
      if (j == bad_at) begin
        xfer(1'b1, 32'h0C, $urandom, 4'h3, 1'b0, d);
        rd_check("ctrl_after_partial_sel", 32'h08, exp_ctrl());
      end
      m_msg[j] = $urandom;
      wr(32'h0C, m_msg[j]);
      check("start_pulse", {31'b0, start_seen}, {31'b0, j == NMSG - 1});
      m_msg_idx = (j == NMSG - 1) ? 0 : j + 1;
    end
    m_state = 1;
  endtask

  task automatic core_finish();
    @(negedge clk);
    for (int k = 0; k < NDIG; k++) begin
      m_dig[k] = $urandom;
      digest_i[32*k +: 32] = m_dig[k];
    end
    core_done_i = 1'b1;
    @(negedge clk);
    core_done_i = 1'b0;
    m_state = 2; m_dig_idx = 0;
  endtask

  initial begin
    logic [31:0] d;
    bus.wbs_stb_i = 0; bus.wbs_cyc_i = 0; bus.wbs_we_i = 0;
    bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {26'b0, bus.wbs_ack_o, start_o, core_rst_o, done, irq, |msg_o}, 32'd0);
    check("rst_dat", bus.wbs_dat_o, 32'd0);
    rst_n = 1'b1;

    rd_check("nr", 32'h00, 32'd5);
    rd_check("id", 32'h04, ID);
    rd_check("msg_in_read", 32'h0C, EINVAL);
    rd_check("unmapped_read", 32'h20, EINVAL);
    rd_check("ctrl_reset", 32'h08, exp_ctrl());

    for (int it = 0; it < 5; it++) begin
      ctrl_write(32'h1 | (32'($urandom_range(0, 1)) << 2));
      if (it == 0) begin
        core_finish();
        m_state = 0;
        check("done_outside_run", {31'b0, done}, 32'd0);
      end
      rd_check("digest_idle", 32'h10, EINVAL);
      load_block((it % 2 == 0) ? int'($urandom_range(0, NMSG - 1)) : -1);
      for (int k = 0; k < NMSG; k++) check("msg_word", msg_o[32*k +: 32], m_msg[k]);
      rd_check("ctrl_run", 32'h08, exp_ctrl());
      rd_check("digest_run", 32'h10, EINVAL);
      rd_check("ctrl_dig_idx_kept", 32'h08, exp_ctrl());
      if (it % 2 == 1) begin
        wr(32'h0C, $urandom);
        m_err = 1;
        rd_check("ctrl_err", 32'h08, exp_ctrl());
      end
      if (it == 2) begin
        xfer(1'b1, 32'h08, 32'h1, 4'hF, 1'b1, d);
        m_state = 0; m_msg_idx = 0; m_dig_idx = 0; m_err = 0; m_irq_en = 0;
        check("on_beats_done", {31'b0, done}, 32'd0);
        rd_check("ctrl_on_beats_done", 32'h08, exp_ctrl());
        rd_check("digest_after_on", 32'h10, EINVAL);
        continue;
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      core_finish();
      check("done_pin", {31'b0, done}, 32'd1);
      check("irq_on_done", {31'b0, irq}, {31'b0, m_irq_en});
      begin
        int n = (it == 0) ? 6 : int'($urandom_range(1, 7));
        for (int r = 0; r < n; r++) begin
          rd_check("digest_word", 32'h10, m_dig[m_dig_idx]);
          m_dig_idx = (m_dig_idx + 1) % NDIG;
        end
      end
      if (it % 2 == 1) begin
        wr(32'h0C, $urandom);
        rd_check("ctrl_err_done", 32'h08, exp_ctrl());
      end
      rd_check("ctrl_done", 32'h08, exp_ctrl());
      ctrl_write(32'h8 | (32'(m_irq_en) << 2));
      check("irq_cleared", {30'b0, irq, done}, 32'd0);
      rd_check("ctrl_after_clr", 32'h08, exp_ctrl());
    end

    wr(32'h08, 32'h2);
    check("core_rst_pulse", {31'b0, rst_seen}, 32'd1);
    m_irq_en = 0;

`ifdef HASH_WB_WATCHDOG_EN
    ctrl_write(32'h5);
    load_block(-1);
    repeat (TMO - 2) @(posedge clk);
    #1;
    check("wd_early", {30'b0, core_rst_o, irq}, 32'd0);
    @(posedge clk); #1;
    check("wd_fire", {30'b0, core_rst_o, irq}, 32'd3);
    m_state = 0; m_panic = 1;
    rd_check("ctrl_panic", 32'h08, exp_ctrl());
`endif

    ctrl_write(32'h1);
    load_block(-1);
    rd_check("nr_before_abort", 32'h00, 32'd5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", {26'b0, bus.wbs_ack_o, start_o, core_rst_o, done, irq, |msg_o}, 32'd0);
    check("abort_dat", bus.wbs_dat_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_state = 0; m_msg_idx = 0; m_dig_idx = 0; m_err = 0; m_panic = 0; m_irq_en = 0;
    rd_check("ctrl_after_abort", 32'h08, exp_ctrl());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule

`default_nettype wire
